dds_psk_carrier_gen: RTL and testbench
======================================

// Module: dds_psk_carrier_gen
// PURPOSE
//  Parametrised NCO/DDS carrier generator with built-in phase modulation for the 2PSK/2DPSK/QPSK transmit path.
//  Phase accumulator drives a registered full-wave sine ROM (I) and a +90 deg tap (Q).
//  Symbols enter through a valid/ready handshake and are applied only at carrier-period symbol boundaries.
//  Sits between the bit/dibit source and the DAC driver.
// PARAMETERS
//  ACC_W      16  phase accumulator width (bits)
//  LUT_AW     7   ROM address width; N = 2**LUT_AW samples per carrier period
//  DATA_W     8   sample width, offset-binary (unsigned)
//  SYM_CYCLES 4   carrier periods (accumulator wraps) per symbol, >=1
// PORTS
//  clk        in  1        system clock
//  reset_n    in  1        asynchronous active-low reset
//  enable     in  1        advance accumulator/pipeline this cycle
//  freq_word  in  ACC_W    phase increment per enabled cycle
//  mode       in  2        00 CW, 01 2PSK, 10 2DPSK, 11 QPSK (sampled at boundary)
//  sym_valid  in  1        sym_data valid
//  sym_data   in  2        bit in [0] (2PSK/2DPSK); Gray dibit [1:0] (QPSK)
//  sym_ready  out 1        boundary cycle; symbol accepted when valid&ready
//  dataout    out DATA_W   in-phase sample
//  dataout_q  out DATA_W   quadrature sample (ROM[addr+N/4])
//  dout_valid out 1        samples valid (enable delayed 2 cycles)
//  underrun   out 1        sticky: boundary passed with sym_valid low
// BEHAVIOUR
//  - Reset: acc, offset, wrap counter, DPSK state, mode_r, pipeline regs, all outputs = 0. Async, any time.
//  - ROM[k] = round((2**DATA_W-1)/2*(1-cos(2*pi*k/N))), round half up; ROM[0]=0, ROM[N/2]=2**DATA_W-1.
//    Constant table, not reloaded at reset.
//  - Enabled cycle: {carry,acc} <= acc + freq_word (mod 2**ACC_W). enable=0 freezes acc, counter, pipeline.
//    dout_valid <= 0 in stage order.
//  - Stage1 (reg): p1 <= acc[ACC_W-1 -: LUT_AW] + offset (mod N), using current acc/offset.
//  - Stage2 (reg): dataout <= ROM[p1], dataout_q <= ROM[p1+N/4 mod N].
//    Latency acc->dataout 2 enabled cycles. dout_valid = enable delayed 2 cycles.
//  - Wrap counter wc: increments on carry; wraps at SYM_CYCLES-1.
//  - sym_ready (comb) = enable & carry & (wc==SYM_CYCLES-1). High exactly one cycle per symbol.
//  - At boundary, mode_r <= mode; offset set per new mode_r and sym_data (units of N/4):
//    CW: 0.
//    2PSK: bit?N/2:0.
//    2DPSK: d <= d^bit, offset = d?N/2:0.
//    QPSK Gray: 00->0, 01->N/4, 11->N/2, 10->3N/4.
//  - New offset first used by stage1 in the cycle after the boundary, i.e. with the post-wrap acc value.
//  - Boundary with sym_valid=0: offset and d held, underrun<=1; cleared only by reset.
//  - In CW, symbols are still consumed at boundaries; their data is ignored.
//  - Mode change mid-symbol has no effect until the next boundary.
//  - DPSK state d is reset to 0 on entry to 2DPSK (mode_r changes to 10).
//  - freq_word=0: no wraps, sym_ready never asserts, outputs constant.
//  - freq_word>=2**(ACC_W-1): still legal; wraps counted per carry.
// TESTING
//  - Reset mid-run (reset_n low 3 cycles) -> dataout, dataout_q, dout_valid, underrun, sym_ready = 0.
//    First dout_valid 2 cycles after enable.
//  - Defaults, CW, freq_word=512 -> 1 ROM step/cycle.
//    dataout: 0, ROM[1].. peaks 255 at step 64; period 128 cycles; dataout_q leads by 32 steps.
//    sym_ready every 512 cycles.
//  - 2PSK, symbols 1,0,1 -> offset 64,0,64.
//    Sample after each boundary = ROM[64]=255, ROM[0]=0, 255.
//  - 2DPSK from entry, bits 1,1,0,1 -> d = 1,0,0,1 -> offsets 64,0,0,64.
//  - QPSK dibits 00,01,11,10 -> offsets 0,32,64,96.
//    First post-boundary I = 0,128,255,128.
//  - sym_valid low at one boundary -> offset held, underrun=1 sticky.
//    Later symbols still accepted; enable=0 for 10 cycles freezes dataout and drops dout_valid.

Source files
------------

// File: rtl/dds_psk_carrier_gen.sv
// dds_psk_carrier_gen
//   NCO/DDS carrier generator with built-in phase modulation for the
//   2PSK / 2DPSK / QPSK transmit path. A phase accumulator addresses a
//   full-wave raised-cosine sample table. The in-phase sample and a +90 degree
//   quadrature tap are both registered. Symbols arrive over a valid/ready
//   handshake and take effect only on symbol boundaries. A symbol boundary is
//   the last accumulator wrap of a symbol.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   enable     in   advance accumulator / pipeline this cycle
//   freq_word  in   phase increment per enabled cycle (ACC_W bits)
//   mode       in   00 CW, 01 2PSK, 10 2DPSK, 11 QPSK (taken at boundary)
//   sym_valid  in   sym_data valid
//   sym_data   in   bit in [0] (2PSK/2DPSK), Gray dibit [1:0] (QPSK)
//   sym_ready  out  boundary cycle; symbol accepted when valid & ready
//   dataout    out  in-phase sample, offset binary
//   dataout_q  out  quadrature sample (table[addr + N/4])
//   dout_valid out  enable delayed by two cycles
//   underrun   out  sticky: a boundary passed with sym_valid low
module dds_psk_carrier_gen #(
    parameter int ACC_W      = 16,
    parameter int LUT_AW     = 7,
    parameter int DATA_W     = 8,
    parameter int SYM_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic [1:0]        mode,
    input  logic              sym_valid,
    input  logic [1:0]        sym_data,
    output logic              sym_ready,
    output logic [DATA_W-1:0] dataout,
    output logic [DATA_W-1:0] dataout_q,
    output logic              dout_valid,
    output logic              underrun
);

    localparam int N    = 32'sd1 << LUT_AW;
    localparam int WC_W = (SYM_CYCLES > 32'sd1) ? $clog2(SYM_CYCLES) : 32'sd1;
    localparam logic [WC_W-1:0]   WC_LAST = WC_W'(SYM_CYCLES - 32'sd1);
    localparam logic [LUT_AW-1:0] OFF_Q0  = LUT_AW'(32'sd0);
    localparam logic [LUT_AW-1:0] OFF_Q1  = LUT_AW'(N / 32'sd4);
    localparam logic [LUT_AW-1:0] OFF_Q2  = LUT_AW'(N / 32'sd2);
    localparam logic [LUT_AW-1:0] OFF_Q3  = LUT_AW'((32'sd3 * N) / 32'sd4);
    localparam logic [1:0] MODE_CW   = 2'b00;
    localparam logic [1:0] MODE_PSK  = 2'b01;
    localparam logic [1:0] MODE_DPSK = 2'b10;
    localparam logic [1:0] MODE_QPSK = 2'b11;

    // Fixed point with 30 fractional bits; large enough that table rounding
    // is exact for any practical DATA_W.
    localparam longint FX_ONE    = 64'sd1073741824;
    localparam longint FX_TWO_PI = 64'sd6746518852;

    // Taylor-series cosine of th (fixed point, 0 <= th < pi/2).
    function automatic longint fx_cos(input longint th);
        longint sum_v;
        longint term_v;
        sum_v  = FX_ONE;
        term_v = FX_ONE;
        for (int n = 1; n <= 10; n++) begin
            term_v = -((((term_v * th) / FX_ONE) * th) / FX_ONE)
                     / longint'((32'sd2 * n - 32'sd1) * (32'sd2 * n));
            sum_v  = sum_v + term_v;
        end
        return sum_v;
    endfunction

    // Taylor-series sine of th (fixed point, 0 <= th < pi/2).
    function automatic longint fx_sin(input longint th);
        longint sum_v;
        longint term_v;
        sum_v  = th;
        term_v = th;
        for (int n = 1; n <= 10; n++) begin
            term_v = -((((term_v * th) / FX_ONE) * th) / FX_ONE)
                     / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
            sum_v  = sum_v + term_v;
        end
        return sum_v;
    endfunction

    // Table entry k: round-half-up of (2^DATA_W-1)/2 * (1 - cos(2*pi*k/N)).
    // The angle is folded into the first quadrant so that the quadrant
    // points (k multiple of N/4) are exact, because ties land there.
    function automatic logic [DATA_W-1:0] rom_value(input int k);
        int     quad;
        int     rem;
        longint th;
        longint c;
        longint full;
        quad = k / (N / 32'sd4);
        rem  = k % (N / 32'sd4);
        th   = (FX_TWO_PI * longint'(rem)) / longint'(N);
        case (quad)
            32'sd0:  c = fx_cos(th);
            32'sd1:  c = -fx_sin(th);
            32'sd2:  c = -fx_cos(th);
            default: c = fx_sin(th);
        endcase
        full = (64'sd1 <<< DATA_W) - 64'sd1;
        return DATA_W'((full * (FX_ONE - c) + FX_ONE) / (64'sd2 * FX_ONE));
    endfunction

    logic [DATA_W-1:0] rom_s [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [DATA_W-1:0] ROM_V = rom_value(k);
        assign rom_s[k] = ROM_V;
    end

    logic [ACC_W-1:0]  acc_r;
    logic [WC_W-1:0]   wc_r;
    logic [LUT_AW-1:0] offset_r;
    logic              d_r;
    logic [1:0]        mode_r;
    logic [LUT_AW-1:0] p1_r;
    logic              v1_r;

    logic [ACC_W:0]    sum_s;
    logic              carry_s;
    logic              boundary_s;
    logic [LUT_AW-1:0] q_addr_s;
    logic [LUT_AW-1:0] offset_nxt_s;
    logic              d_nxt_s;
    logic              d_base_s;

    assign sum_s      = {1'b0, acc_r} + {1'b0, freq_word};
    assign carry_s    = sum_s[ACC_W];
    assign boundary_s = enable & carry_s & (wc_r == WC_LAST);
    assign sym_ready  = boundary_s;
    assign q_addr_s   = p1_r + OFF_Q1;

    // Phase offset and DPSK state that take effect if this cycle is a boundary.
    always_comb begin
        offset_nxt_s = offset_r;
        d_nxt_s      = d_r;
        // Entering 2DPSK restarts the differential reference at 0.
        if ((mode == MODE_DPSK) && (mode_r != MODE_DPSK)) begin
            d_base_s = 1'b0;
        end else begin
            d_base_s = d_r;
        end
        if (sym_valid) begin
            case (mode)
                MODE_CW: begin
                    offset_nxt_s = OFF_Q0;
                end
                MODE_PSK: begin
                    offset_nxt_s = sym_data[0] ? OFF_Q2 : OFF_Q0;
                end
                MODE_DPSK: begin
                    d_nxt_s      = d_base_s ^ sym_data[0];
                    offset_nxt_s = d_nxt_s ? OFF_Q2 : OFF_Q0;
                end
                MODE_QPSK: begin
                    case (sym_data)
                        2'b00:   offset_nxt_s = OFF_Q0;
                        2'b01:   offset_nxt_s = OFF_Q1;
                        2'b11:   offset_nxt_s = OFF_Q2;
                        default: offset_nxt_s = OFF_Q3;
                    endcase
                end
                default: begin
                    offset_nxt_s = OFF_Q0;
                end
            endcase
        end else begin
            // Missing symbol: phase held, only the entry reset of d applies.
            d_nxt_s = d_base_s;
        end
    end

    // Accumulator, wrap counter, symbol state and the two-stage sample pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r      <= '0;
            wc_r       <= '0;
            offset_r   <= '0;
            d_r        <= 1'b0;
            mode_r     <= 2'b00;
            p1_r       <= '0;
            v1_r       <= 1'b0;
            dataout    <= '0;
            dataout_q  <= '0;
            dout_valid <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            v1_r       <= enable;
            dout_valid <= v1_r;
            if (enable) begin
                acc_r     <= sum_s[ACC_W-1:0];
                // Stage 1 uses the pre-update acc and offset, so a new offset
                // first meets the post-wrap accumulator value.
                p1_r      <= acc_r[ACC_W-1 -: LUT_AW] + offset_r;
                dataout   <= rom_s[p1_r];
                dataout_q <= rom_s[q_addr_s];
                if (carry_s) begin
                    wc_r <= (wc_r == WC_LAST) ? '0 : wc_r + 1'b1;
                end else begin
                    wc_r <= wc_r;
                end
            end else begin
                acc_r <= acc_r;
            end
            if (boundary_s) begin
                mode_r   <= mode;
                offset_r <= offset_nxt_s;
                d_r      <= d_nxt_s;
                if (!sym_valid) begin
                    underrun <= 1'b1;
                end else begin
                    underrun <= underrun;
                end
            end else begin
                mode_r <= mode_r;
            end
        end
    end

endmodule

// File: tb/tb_dds_psk_carrier_gen.sv
module tb_dds_psk_carrier_gen;

    localparam int  N       = 128;
    localparam int  SYM_LEN = 512;   // 4 wraps of 128 steps at freq_word 512
    localparam int  NSYM    = 15;
    localparam real PI      = 3.141592653589793;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [15:0] freq_word;
    logic [1:0] mode;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic [7:0] dataout;
    logic [7:0] dataout_q;
    logic       dout_valid;
    logic       underrun;

    dds_psk_carrier_gen #(
        .ACC_W(16), .LUT_AW(7), .DATA_W(8), .SYM_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .freq_word(freq_word),
        .mode(mode), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_ready(sym_ready), .dataout(dataout), .dataout_q(dataout_q),
        .dout_valid(dout_valid), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int i; int q; } samp_t;
    typedef struct { logic [1:0] mode; logic valid; logic [1:0] data; int off; } sym_t;

    samp_t sbq[$];
    sym_t  syms[NSYM];
    int    rom[N];
    int    checks   = 0;
    int    failures = 0;

    // reference state
    int m_ph, m_off, m_p1, m_i, m_q, ecnt, sidx;
    bit m_v1, m_v2, m_under;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_sym(input int idx, input logic [1:0] md, input logic vl,
                           input logic [1:0] dt, input int off);
        syms[idx].mode  = md;
        syms[idx].valid = vl;
        syms[idx].data  = dt;
        syms[idx].off   = off;
    endtask

    task automatic drive_sym();
        if (sidx < NSYM) begin
            mode      = syms[sidx].mode;
            sym_valid = syms[sidx].valid;
            sym_data  = syms[sidx].data;
        end else begin
            mode      = 2'b00;
            sym_valid = 1'b1;
            sym_data  = 2'b00;
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_off = 0; m_p1 = 0; m_i = 0; m_q = 0; ecnt = 0;
        m_v1 = 1'b0; m_v2 = 1'b0; m_under = 1'b0;
        sbq.delete();
    endtask

    // One clock cycle: starts and ends just after a falling edge.
    task automatic step(input bit en);
        bit bnd;
        enable = en;
        bnd = en && ((ecnt % SYM_LEN) == SYM_LEN - 1);
        #1;
        chk("sym_ready", {31'd0, sym_ready}, {31'd0, bnd});
        @(posedge clk);
        if (en) begin
            m_i  = rom[m_p1];
            m_q  = rom[(m_p1 + N / 4) % N];
            m_p1 = (m_ph + m_off) % N;
            m_ph = (m_ph + 1) % N;
            ecnt++;
            if (bnd && (sidx < NSYM)) begin
                m_off = syms[sidx].off;
                if (!syms[sidx].valid) m_under = 1'b1;
                sidx++;
            end
        end
        m_v2 = m_v1;
        m_v1 = en;
        if (m_v2) sbq.push_back('{m_i, m_q});
        #1;
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_v2});
        chk("underrun", {31'd0, underrun}, {31'd0, m_under});
        @(negedge clk);
        if (bnd) drive_sym();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dataout"},    {24'd0, dataout},    32'd0);
        chk({tag, "_dataout_q"},  {24'd0, dataout_q},  32'd0);
        chk({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
        chk({tag, "_underrun"},   {31'd0, underrun},   32'd0);
        chk({tag, "_sym_ready"},  {31'd0, sym_ready},  32'd0);
    endtask

    // Scoreboard monitor: pops one expected sample per valid output.
    always @(negedge clk) begin : monitor
        samp_t e;
        if (reset_n && dout_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=valid_sample required=no_sample (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("sample_i", {24'd0, dataout},   e.i);
                chk("sample_q", {24'd0, dataout_q}, e.q);
            end
        end
    end

    initial begin : stim
        logic [7:0] frozen_i;
        bit gap_done;
        for (int k = 0; k < N; k++)
            rom[k] = $rtoi($floor(127.5 * (1.0 - $cos(2.0 * PI * k / N)) + 0.5 + 1.0e-9));

        // mode, valid, data, expected offset after that boundary
        set_sym(0,  2'b00, 1'b1, 2'b00, 0);
        set_sym(1,  2'b01, 1'b1, 2'b01, 64);
        set_sym(2,  2'b01, 1'b1, 2'b00, 0);
        set_sym(3,  2'b01, 1'b1, 2'b01, 64);
        set_sym(4,  2'b10, 1'b1, 2'b01, 64);   // entry: d = 0^1 = 1
        set_sym(5,  2'b10, 1'b1, 2'b01, 0);    // d = 0
        set_sym(6,  2'b10, 1'b1, 2'b00, 0);    // d = 0
        set_sym(7,  2'b10, 1'b1, 2'b01, 64);   // d = 1
        set_sym(8,  2'b11, 1'b1, 2'b00, 0);
        set_sym(9,  2'b11, 1'b1, 2'b01, 32);
        set_sym(10, 2'b11, 1'b1, 2'b11, 64);
        set_sym(11, 2'b11, 1'b1, 2'b10, 96);
        set_sym(12, 2'b11, 1'b0, 2'b11, 96);   // missing symbol: held
        set_sym(13, 2'b11, 1'b1, 2'b01, 32);
        set_sym(14, 2'b00, 1'b1, 2'b11, 0);    // CW ignores data

        reset_n   = 1'b0;
        enable    = 1'b0;
        freq_word = 16'd512;
        sidx      = 0;
        gap_done  = 1'b0;
        drive_sym();
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero_outputs("por");
        reset_n = 1'b1;

        // Short CW run, then reset mid-run with enable held high.
        repeat (200) step(1'b1);
        reset_n = 1'b0;
        enable  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_zero_outputs("midrst");
            @(negedge clk);
        end
        reset_n = 1'b1;
        model_reset();

        // Full symbol sequence with a 10-cycle enable gap in symbol 13.
        while (sidx < NSYM) begin
            if (!gap_done && (sidx == 13) && ((ecnt % SYM_LEN) == 100)) begin
                frozen_i = dataout;
                for (int g = 0; g < 10; g++) begin
                    step(1'b0);
                    chk("freeze_dataout", {24'd0, dataout}, {24'd0, frozen_i});
                end
                gap_done = 1'b1;
            end else begin
                step(1'b1);
            end
        end
        repeat (20) step(1'b1);
        step(1'b0);
        step(1'b0);
        @(posedge clk);
        #1;
        chk("sb_drained", sbq.size(), 32'd0);
        chk("gap_seen", {31'd0, gap_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
